// File: rtl/cla_serial_add32.sv
// Nibble-serial adder/subtractor: one 4-bit carry-lookahead slice is reused
// once per nibble, so a WIDTH-bit operation takes WIDTH/4 RUN cycles.
// WIDTH must be a multiple of 4 and at least 8.

// 4-bit carry-lookahead slice with group propagate/generate outputs.
module cla_serial_add32_cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       p_o,
  output logic       g_o
);
  logic [3:0] p, g, c;

  // Lookahead carries, group P/G and sum bits.
  always_comb begin
    p     = a_i ^ b_i;
    g     = a_i & b_i;
    c[0]  = cin_i;
    c[1]  = g[0] | (p[0] & cin_i);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);
    sum_o = p ^ c;
    p_o   = &p;
    g_o   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end
endmodule

module cla_serial_add32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NNIB = WIDTH / 4;
  localparam int CW   = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NNIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, work_q, work_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;

  logic [3:0]       nib_sum;
  logic             grp_p, grp_g, carry_nxt;
  logic [WIDTH-1:0] b_eff;

  cla_serial_add32_cla4 u_slice (
    .a_i   (a_q[3:0]),
    .b_i   (b_q[3:0]),
    .cin_i (carry_q),
    .sum_o (nib_sum),
    .p_o   (grp_p),
    .g_o   (grp_g)
  );

  // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
  assign b_eff     = sub ? ~b : b;
  assign carry_nxt = grp_g | (grp_p & carry_q);

  // Next-state and datapath updates; everything holds unless written.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_eff;
          carry_d = sub;
          cnt_d   = '0;
          work_d  = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b_eff[WIDTH-1];
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Result nibbles enter from the top, so after NNIB steps the LSB
        // nibble has reached bit 0.
        work_d  = {nib_sum, work_q[WIDTH-1:4]};
        a_d     = {4'b0, a_q[WIDTH-1:4]};
        b_d     = {4'b0, b_q[WIDTH-1:4]};
        carry_d = carry_nxt;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = {nib_sum, work_q[WIDTH-1:4]};
          cout_d  = carry_nxt;
          ovf_d   = (a_msb_q == b_msb_q) & (nib_sum[3] != a_msb_q);
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_cla_serial_add32.sv
// Directed bench for the nibble-serial adder/subtractor.
module tb_cla_serial_add32;
  logic        clk, rst_n, start, sub;
  logic [31:0] a, b;
  logic        busy, done, cout, ovf;
  logic [31:0] sum;

  int vec  = 0;
  int errs = 0;

  cla_serial_add32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one start pulse; returns at the negedge right after the start edge.
  task automatic launch(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts);
    @(negedge clk);
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done, counting busy cycles and busy/done overlap.
  task automatic wait_done(output int bcyc, output bit seen, output bit overlap);
    bcyc = 0; seen = 1'b0; overlap = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy && done) overlap = 1'b1;
      if (done) begin seen = 1'b1; break; end
      if (busy) bcyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #3 rst_n = 1'b0;
    #1;
    vec++;
    if ({busy, done, sum, cout, ovf} !== 35'd0) begin
      errs++;
      $display("FAIL reset_outputs got busy=%b done=%b sum=%h cout=%b ovf=%b exp all 0",
               busy, done, sum, cout, ovf);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL reset_idle got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] ta [9] = '{32'h0000000F, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h00000003,
                            32'h12345678, 32'h80000000, 32'h00000005, 32'h00000000};
    logic [31:0] tb_v [9] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000005,
                              32'h11111111, 32'h80000000, 32'h00000005, 32'h00000001};
    logic        ts [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] es [9] = '{32'h00000010, 32'h00000000, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE,
                            32'h23456789, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
    logic        ec [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        eo [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int bcyc; bit seen, ovl;
    for (int i = 0; i < 9; i++) begin
      launch(ta[i], tb_v[i], ts[i]);
      wait_done(bcyc, seen, ovl);
      vec++;
      if (!seen || bcyc != 8 || ovl) begin
        errs++;
        $display("FAIL vec%0d_timing got done=%b busy_cycles=%0d overlap=%b exp 1 8 0", i, seen, bcyc, ovl);
      end
      vec++;
      if (sum !== es[i] || cout !== ec[i] || ovf !== eo[i]) begin
        errs++;
        $display("FAIL vec%0d_result got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                 i, sum, cout, ovf, es[i], ec[i], eo[i]);
      end
    end
  endtask

  // Previous result is 0xFFFFFFFF (0 - 1); it must hold during the next RUN.
  task automatic test_start_during_run();
    int bcyc; bit seen, ovl;
    launch(32'h12345678, 32'h11111111, 1'b0);
    @(negedge clk); @(negedge clk);
    vec++;
    if (sum !== 32'hFFFFFFFF || cout !== 1'b0) begin
      errs++;
      $display("FAIL hold_during_run got sum=%h cout=%b exp FFFFFFFF 0", sum, cout);
    end
    a = 32'hFFFFFFFF; b = 32'h00000001; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(bcyc, seen, ovl);
    vec++;
    if (!seen || sum !== 32'h23456789 || cout !== 1'b0 || ovf !== 1'b0) begin
      errs++;
      $display("FAIL ignore_start got done=%b sum=%h cout=%b ovf=%b exp 1 23456789 0 0",
               seen, sum, cout, ovf);
    end
    @(negedge clk);
    vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL single_done got done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_back_to_back();
    int bcyc; bit seen, ovl;
    @(negedge clk);
    a = 32'h0000FFFF; b = 32'h00000001; sub = 1'b0; start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    vec++;
    if (!seen || sum !== 32'h00010000 || cout !== 1'b0 || ovf !== 1'b0) begin
      errs++;
      $display("FAIL b2b_first got done=%b sum=%h cout=%b ovf=%b exp 1 00010000 0 0",
               seen, sum, cout, ovf);
    end
    a = 32'h00000010; b = 32'h00000020; sub = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vec++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errs++;
      $display("FAIL b2b_accept got busy=%b done=%b exp 1 0", busy, done);
    end
    wait_done(bcyc, seen, ovl);
    vec++;
    if (!seen || bcyc != 8 || sum !== 32'hFFFFFFF0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errs++;
      $display("FAIL b2b_second got done=%b cycles=%0d sum=%h cout=%b ovf=%b exp 1 8 FFFFFFF0 0 0",
               seen, bcyc, sum, cout, ovf);
    end
  endtask

  task automatic test_reset_mid_run();
    int bcyc; bit seen, ovl, stray;
    launch(32'hFFFFFFFF, 32'h00000001, 1'b0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if ({busy, done, sum, cout, ovf} !== 35'd0) begin
      errs++;
      $display("FAIL reset_mid_run got busy=%b done=%b sum=%h cout=%b ovf=%b exp all 0",
               busy, done, sum, cout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) stray = 1'b1;
    end
    vec++;
    if (stray) begin
      errs++;
      $display("FAIL abort_no_done got activity=1 exp 0");
    end
    launch(32'h7FFFFFFF, 32'h00000001, 1'b0);
    wait_done(bcyc, seen, ovl);
    vec++;
    if (!seen || bcyc != 8 || sum !== 32'h80000000 || cout !== 1'b0 || ovf !== 1'b1) begin
      errs++;
      $display("FAIL after_reset got done=%b cycles=%0d sum=%h cout=%b ovf=%b exp 1 8 80000000 0 1",
               seen, bcyc, sum, cout, ovf);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
